// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and widths for the SRAM arbiter slice.
//   state_t : access sequencer states
//   port_t  : requester identity (CPU memory port / debug loader port)
//   ADDR_W  : SRAM word address width (1M words)
//   DATA_W  : SRAM data width
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    typedef enum logic {
        CPU,
        DBG
    } port_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Bundles both requester ports and the SRAM strobe/data bus.
//   cpu_* / dbg_* : level request, we, address, write data in; read data and
//                   one-cycle ack out
//   CE UB LB OE WE: active-low SRAM controls
//   ADDR          : SRAM word address
//   Data_write    : data toward the tristate buffer (enabled by ~WE)
//   Data_read     : data from the tristate buffer
//   busy          : arbiter is not idle
// Modports: slave = the arbiter, master = the surrounding system.
// ---------------------------------------------------------------------------
interface sram_arbiter_if;
    import sram_arb_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              CE;
    logic              UB;
    logic              LB;
    logic              OE;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_write;
    logic [DATA_W-1:0] Data_read;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  Data_read,
        output cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
        output CE, UB, LB, OE, WE, ADDR, Data_write, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output Data_read,
        input  cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
        input  CE, UB, LB, OE, WE, ADDR, Data_write, busy
    );

endinterface

// File: rtl/sram_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant.
//   req_cpu, req_dbg : pending requests
//   last_grant       : port that won the previous arbitration
//   grant_valid      : at least one request is pending
//   grant            : winning port (meaningful only with grant_valid)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic  req_cpu,
    input  logic  req_dbg,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant
);

    // A lone request always wins; on contention the port that did not win
    // last time gets the grant so neither side can be starved.
    always_comb begin
        grant_valid = req_cpu | req_dbg;
        grant       = CPU;
        if (req_cpu && req_dbg) begin
            grant = (last_grant == CPU) ? DBG : CPU;
        end else if (req_dbg) begin
            grant = DBG;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Sequences every access to the external 1Mx16 asynchronous SRAM for the CPU
// memory port and the debug/loader port. All outputs are registered.
//   Clk   : system clock
//   Reset : synchronous, active-low
//   bus   : sram_arbiter_if.slave (both requester ports + SRAM bus)
// Parameters: READ_WAIT (CE/OE low cycles before capture), WRITE_PULSE
// (WE low cycles), CNT_W (wait counter width).
// ---------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 2,
    parameter int CNT_W       = 4
) (
    input logic           Clk,
    input logic           Reset,
    sram_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_t             last_grant_q, last_grant_d;
    port_t             owner_q, owner_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dwr_q, dwr_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              busy_q, busy_d;

    logic              grant_valid;
    port_t             grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req_cpu     (bus.cpu_req),
        .req_dbg     (bus.dbg_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Mux the winning requester's command so only one set of latches exists.
    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (grant == DBG) begin
            sel_we    = bus.dbg_we;
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
        end
    end

    // Next-state and next-output logic. Every output is computed one cycle
    // ahead and registered, so the strobes change exactly on state entry.
    // The wait counter is loaded with (parameter - 1) on entering a timed
    // state and only decremented while non-zero, so it cannot wrap.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ce_d         = ce_q;
        oe_d         = oe_q;
        we_d         = we_q;
        addr_d       = addr_q;
        dwr_d        = dwr_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant;
                    owner_d      = grant;
                    addr_d       = sel_addr;
                    ce_d         = 1'b0;
                    if (sel_we) begin
                        state_d = WR_SETUP;
                        dwr_d   = sel_wdata;
                    end else begin
                        state_d = RD_ACC;
                        oe_d    = 1'b0;
                        cnt_d   = CNT_W'(READ_WAIT - 1);
                    end
                end
            end
            RD_ACC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    if (owner_q == CPU) begin
                        cpu_rdata_d = bus.Data_read;
                        cpu_ack_d   = 1'b1;
                    end else begin
                        dbg_rdata_d = bus.Data_read;
                        dbg_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                we_d    = 1'b0;
                cnt_d   = CNT_W'(WRITE_PULSE - 1);
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                    we_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_d = DONE;
                ce_d    = 1'b1;
                if (owner_q == CPU) begin
                    cpu_ack_d = 1'b1;
                end else begin
                    dbg_ack_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ce_d    = 1'b1;
                oe_d    = 1'b1;
                we_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset aborts any access on the same edge,
    // returning the strobes high without acknowledging; last_grant starts at
    // DBG so the CPU wins the first contention.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= DBG;
            owner_q      <= CPU;
            ce_q         <= 1'b1;
            oe_q         <= 1'b1;
            we_q         <= 1'b1;
            addr_q       <= '0;
            dwr_q        <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ce_q         <= ce_d;
            oe_q         <= oe_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            dwr_q        <= dwr_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            busy_q       <= busy_d;
        end
    end

    // Byte lanes follow CE: only full-word accesses are issued.
    assign bus.CE         = ce_q;
    assign bus.UB         = ce_q;
    assign bus.LB         = ce_q;
    assign bus.OE         = oe_q;
    assign bus.WE         = we_q;
    assign bus.ADDR       = addr_q;
    assign bus.Data_write = dwr_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter with a small behavioural SRAM model
// (4K words, address bits [11:0]). Inputs change on the falling edge;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int RW = 2;
    localparam int WP = 2;

    logic Clk;
    logic Reset;

    sram_arbiter_if bus_if ();

    sram_arbiter #(
        .READ_WAIT   (RW),
        .WRITE_PULSE (WP),
        .CNT_W       (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Asynchronous SRAM model: preloaded once, written while CE and WE are
    // low, read data visible while CE and OE are low.
    logic [15:0] mem [0:4095];
    bit          mem_loaded = 1'b0;

    always @(posedge Clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
            mem[12'h000] <= 16'h0A55;
            mem[12'h123] <= 16'hBEEF;
            mem[12'hFFF] <= 16'h7777;
            mem_loaded   <= 1'b1;
        end else if (!bus_if.CE && !bus_if.WE) begin
            mem[bus_if.ADDR[11:0]] <= bus_if.Data_write;
        end
    end

    assign bus_if.Data_read = (!bus_if.CE && !bus_if.OE) ? mem[bus_if.ADDR[11:0]] : 16'h0000;

    // OE and WE must never be low together outside reset.
    int excl_viol = 0;
    always @(negedge Clk) begin
        if (Reset) begin
            assert (bus_if.OE || bus_if.WE)
            else begin
                excl_viol++;
                $display("[TB] FAIL oe_we_exclusive: OE=%0b WE=%0b at %0t", bus_if.OE, bus_if.WE, $time);
            end
        end
    end

    int compared   = 0;
    int mismatched = 0;
    logic [15:0] exp_cpu_rdata;
    logic [15:0] exp_dbg_rdata;

    typedef struct {
        port_t       port;
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input port_t port, input logic req, input logic we,
                                 input logic [19:0] addr, input logic [15:0] wdata);
        if (port == CPU) begin
            bus_if.cpu_req   = req;
            bus_if.cpu_we    = we;
            bus_if.cpu_addr  = addr;
            bus_if.cpu_wdata = wdata;
        end else begin
            bus_if.dbg_req   = req;
            bus_if.dbg_we    = we;
            bus_if.dbg_addr  = addr;
            bus_if.dbg_wdata = wdata;
        end
    endtask

    // Bit order {CE, UB, LB, OE, WE, busy, cpu_ack, dbg_ack}.
    function automatic logic [7:0] strobes();
        return {bus_if.CE, bus_if.UB, bus_if.LB, bus_if.OE, bus_if.WE,
                bus_if.busy, bus_if.cpu_ack, bus_if.dbg_ack};
    endfunction

    // Expected strobes in cycle k (1-based) after the granting edge.
    function automatic logic [7:0] expStrobes(input logic we, input port_t port, input int k);
        logic ce, oe, wel, ack;
        ce = 1'b0; oe = 1'b1; wel = 1'b1; ack = 1'b0;
        if (!we) begin
            if (k <= RW) oe = 1'b0;
            else begin ce = 1'b1; ack = 1'b1; end
        end else begin
            if (k >= 2 && k <= WP + 1) wel = 1'b0;
            if (k == WP + 3) begin ce = 1'b1; ack = 1'b1; end
        end
        return {ce, ce, ce, oe, wel, 1'b1, ack && (port == CPU), ack && (port == DBG)};
    endfunction

    localparam logic [7:0] IDLE_STROBES = 8'hF8;

    // One complete access, checked cycle by cycle; must start and ends on a
    // falling edge with the arbiter idle.
    task automatic doAccess(input int idx, input port_t port, input logic we,
                            input logic [19:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_rdata);
        int total;
        total = we ? WP + 3 : RW + 1;
        applyStimulus(port, 1'b1, we, addr, wdata);
        for (int k = 1; k <= total; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("v%0d strobes c%0d", idx, k), 32'(strobes()), 32'(expStrobes(we, port, k)));
            checkOutput($sformatf("v%0d addr c%0d", idx, k), 32'(bus_if.ADDR), 32'(addr));
            if (we) checkOutput($sformatf("v%0d wdata c%0d", idx, k), 32'(bus_if.Data_write), 32'(wdata));
            if (k == total) begin
                applyStimulus(port, 1'b0, 1'b0, 20'h0, 16'h0);
                if (!we) begin
                    if (port == CPU) exp_cpu_rdata = exp_rdata;
                    else             exp_dbg_rdata = exp_rdata;
                end
                checkOutput($sformatf("v%0d cpu_rdata", idx), 32'(bus_if.cpu_rdata), 32'(exp_cpu_rdata));
                checkOutput($sformatf("v%0d dbg_rdata", idx), 32'(bus_if.dbg_rdata), 32'(exp_dbg_rdata));
            end
        end
        @(negedge Clk);
        checkOutput($sformatf("v%0d back to idle", idx), 32'(strobes()), 32'(IDLE_STROBES));
        if (we) checkOutput($sformatf("v%0d mem[0x%0h]", idx, addr), 32'(mem[addr[11:0]]), 32'(wdata));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] acks;
        bit         seen;

        vecs[0] = '{CPU, 1'b0, 20'h00123, 16'h0000, 16'hBEEF};
        vecs[1] = '{CPU, 1'b1, 20'h00050, 16'h1234, 16'h0000};
        vecs[2] = '{DBG, 1'b0, 20'h00050, 16'h0000, 16'h1234};
        vecs[3] = '{DBG, 1'b1, 20'h00123, 16'hCAFE, 16'h0000};
        vecs[4] = '{CPU, 1'b0, 20'h00123, 16'h0000, 16'hCAFE};
        vecs[5] = '{DBG, 1'b0, 20'h00000, 16'h0000, 16'h0A55};

        Reset = 1'b0;
        applyStimulus(CPU, 1'b0, 1'b0, 20'h0, 16'h0);
        applyStimulus(DBG, 1'b0, 1'b0, 20'h0, 16'h0);
        exp_cpu_rdata = 16'h0000;
        exp_dbg_rdata = 16'h0000;

        // Reset held for three cycles, then released.
        repeat (3) @(negedge Clk);
        checkOutput("reset strobes", 32'(strobes()), 32'(IDLE_STROBES));
        checkOutput("reset addr", 32'(bus_if.ADDR), 32'h0);
        checkOutput("reset data_write", 32'(bus_if.Data_write), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("post-reset strobes", 32'(strobes()), 32'(IDLE_STROBES));
        checkOutput("post-reset addr", 32'(bus_if.ADDR), 32'h0);
        checkOutput("post-reset cpu_rdata", 32'(bus_if.cpu_rdata), 32'h0);
        checkOutput("post-reset dbg_rdata", 32'(bus_if.dbg_rdata), 32'h0);

        // Directed single-port transactions.
        for (int i = 0; i < 6; i++) begin
            doAccess(i, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Simultaneous requests: last winner was DBG, so expect CPU, DBG,
        // CPU, DBG. CPU reads 0x123 (0xCAFE), DBG reads 0x050 (0x1234).
        for (int r = 0; r < 2; r++) begin
            applyStimulus(CPU, 1'b1, 1'b0, 20'h00123, 16'h0);
            applyStimulus(DBG, 1'b1, 1'b0, 20'h00050, 16'h0);
            for (int g = 0; g < 2; g++) begin
                seen = 1'b0;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge Clk);
                    if (bus_if.cpu_ack || bus_if.dbg_ack) seen = 1'b1;
                end
                if (!seen) begin
                    checkOutput($sformatf("contention r%0d g%0d ack timeout", r, g), 32'd1, 32'd0);
                    applyStimulus(CPU, 1'b0, 1'b0, 20'h0, 16'h0);
                    applyStimulus(DBG, 1'b0, 1'b0, 20'h0, 16'h0);
                end else begin
                    acks = {bus_if.cpu_ack, bus_if.dbg_ack};
                    checkOutput($sformatf("contention r%0d g%0d acks", r, g), 32'(acks),
                                (g == 0) ? 32'b10 : 32'b01);
                    if (g == 0) begin
                        checkOutput($sformatf("contention r%0d cpu_rdata", r), 32'(bus_if.cpu_rdata), 32'hCAFE);
                        applyStimulus(CPU, 1'b0, 1'b0, 20'h0, 16'h0);
                    end else begin
                        checkOutput($sformatf("contention r%0d dbg_rdata", r), 32'(bus_if.dbg_rdata), 32'h1234);
                        applyStimulus(DBG, 1'b0, 1'b0, 20'h0, 16'h0);
                    end
                end
            end
            @(negedge Clk);
            checkOutput($sformatf("contention r%0d idle", r), 32'(strobes()), 32'(IDLE_STROBES));
        end
        exp_cpu_rdata = 16'hCAFE;
        exp_dbg_rdata = 16'h1234;

        // CPU changes address and drops req during a read of 0x050.
        applyStimulus(CPU, 1'b1, 1'b0, 20'h00050, 16'h0);
        @(negedge Clk);
        checkOutput("midread addr c1", 32'(bus_if.ADDR), 32'h00050);
        applyStimulus(CPU, 1'b0, 1'b0, 20'h00FFF, 16'h0);
        @(negedge Clk);
        checkOutput("midread addr c2", 32'(bus_if.ADDR), 32'h00050);
        checkOutput("midread strobes c2", 32'(strobes()), 32'(expStrobes(1'b0, CPU, 2)));
        @(negedge Clk);
        checkOutput("midread ack c3", 32'(strobes()), 32'(expStrobes(1'b0, CPU, 3)));
        checkOutput("midread cpu_rdata", 32'(bus_if.cpu_rdata), 32'h1234);
        exp_cpu_rdata = 16'h1234;
        @(negedge Clk);
        checkOutput("midread single ack c4", 32'(strobes()), 32'(IDLE_STROBES));
        @(negedge Clk);
        checkOutput("midread stays idle c5", 32'(strobes()), 32'(IDLE_STROBES));

        // Reset in the middle of the write pulse.
        applyStimulus(CPU, 1'b1, 1'b1, 20'h00FFF, 16'h5A5A);
        @(negedge Clk);
        applyStimulus(CPU, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge Clk);
        checkOutput("wrabort in pulse", 32'(strobes()), 32'(expStrobes(1'b1, CPU, 2)));
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("wrabort strobes", 32'(strobes()), 32'(IDLE_STROBES));
        checkOutput("wrabort addr", 32'(bus_if.ADDR), 32'h0);
        checkOutput("wrabort data_write", 32'(bus_if.Data_write), 32'h0);
        Reset = 1'b1;
        exp_cpu_rdata = 16'h0000;
        exp_dbg_rdata = 16'h0000;
        repeat (2) begin
            @(negedge Clk);
            checkOutput("wrabort no late ack", 32'(strobes()), 32'(IDLE_STROBES));
        end
        doAccess(6, DBG, 1'b0, 20'h00000, 16'h0, 16'h0A55);

        checkOutput("oe_we_exclusive violations", 32'(excl_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
